target_select_rx: RTL and testbench

Receive-side counterpart of the switch-driven target-machine command source. Deserializes the 8N1 UART line carrying target-select bytes, checks framing, and decodes the command (bits [1:0] = 2'b11, id in [6:2], bit 7 = 0) or the all-zero deselect byte. Holds the currently selected machine id for the game-side logic, and forwards every good byte raw for other consumers.

---
 rtl/target_select_rx_pkg.sv | 29 ++
 rtl/target_select_rx_uart_rx_core.sv | 109 ++++++++++
 rtl/target_select_rx.sv | 85 ++++++++
 tb/tb_target_select_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/target_select_rx_pkg.sv
// Shared types and field layout for the target-select UART receiver.
// Latency: n/a (types and helpers only). Backpressure: n/a.
package target_select_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic [1:0] CMD_TAG       = 2'b11;
  localparam logic [7:0] DESELECT_BYTE = 8'h00;
  localparam int         ID_LSB        = 2;
  localparam int         ID_MSB        = 6;
  localparam int         ID_W          = ID_MSB - ID_LSB + 1;
  localparam int         CMD_RSVD_BIT  = 7;

  // A command carries the tag in the low bits and a clear reserved top bit.
  function automatic logic is_cmd(input logic [7:0] b);
    return (b[1:0] == CMD_TAG) && !b[CMD_RSVD_BIT];
  endfunction

  function automatic logic [ID_W-1:0] cmd_id(input logic [7:0] b);
    return b[ID_MSB:ID_LSB];
  endfunction

endpackage

// File: rtl/target_select_rx_uart_rx_core.sv
// 8N1 UART deserializer: 2-flop synchronizer, framing FSM, baud/bit counters.
// Latency: good/frame_err pulse combinational on the mid-stop-bit sample cycle. Backpressure: none.
module target_select_rx_uart_rx_core
  import target_select_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_good,
  output logic       frame_err
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rxs;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;

  // Both flops reset to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    byte_good = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!rxs) state_nxt = ST_START;
      end
      ST_START: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (cnt == HALF_M1) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shift_nxt = {rxs, shift[7:1]};
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
          else                 bit_nxt   = bit_cnt + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          if (rxs) begin
            byte_good = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data = shift;

endmodule

// File: rtl/target_select_rx.sv
// Target-select command receiver: UART byte in, registered machine id / active flag out.
// Latency: all outputs registered on the stop-sample edge. Backpressure: none. Option: TARGET_ID_CHECK_EN.
module target_select_rx
  import target_select_rx_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int MAX_ID   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic [ID_W-1:0] target_id,
  output logic            target_active,
  output logic            target_strobe,
  output logic            frame_err,
  output logic            id_err
);

  localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [ID_W-1:0] MAX_ID_L     = ID_W'(MAX_ID);

  logic [7:0] core_data;
  logic       core_good;
  logic       core_ferr;
  logic       id_ok;

  target_select_rx_uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (core_data),
    .byte_good (core_good),
    .frame_err (core_ferr)
  );

`ifdef TARGET_ID_CHECK_EN
  assign id_ok = (cmd_id(core_data) <= MAX_ID_L);

  always_ff @(posedge clk) begin
    if (rst) id_err <= 1'b0;
    else     id_err <= core_good && is_cmd(core_data) && !id_ok;
  end
`else
  // Without range checking every 5-bit id is a valid selection.
  logic unused_id_range;
  assign unused_id_range = (cmd_id(core_data) > MAX_ID_L);
  assign id_ok           = 1'b1;
  assign id_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      target_id     <= '0;
      target_active <= 1'b0;
      target_strobe <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_valid      <= 1'b0;
      target_strobe <= 1'b0;
      frame_err     <= core_ferr;
      if (core_good) begin
        rx_data  <= core_data;
        rx_valid <= 1'b1;
        if (core_data == DESELECT_BYTE) begin
          target_id     <= '0;
          target_active <= 1'b0;
          target_strobe <= 1'b1;
        end else if (is_cmd(core_data) && id_ok) begin
          // Re-selecting the same id still strobes so the consumer can resync.
          target_id     <= cmd_id(core_data);
          target_active <= 1'b1;
          target_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_target_select_rx.sv
// Bench for target_select_rx: table of frames plus framing, glitch and mid-frame reset sequences.
module tb_target_select_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] target_id;
  logic       target_active;
  logic       target_strobe;
  logic       frame_err;
  logic       id_err;

  always #5 clk = ~clk;

  target_select_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .MAX_ID  (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .target_id    (target_id),
    .target_active(target_active),
    .target_strobe(target_strobe),
    .frame_err    (frame_err),
    .id_err       (id_err)
  );

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic [4:0] id;
    logic       act;
    logic       strobe;
    logic       iderr;
  } exp_t;

  typedef struct packed {
    logic [7:0] b;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[8];
  int   total = 0;
  int   bad = 0;
  int   events = 0;
  logic prev_pulse = 1'b0;

  function automatic exp_t ex(input logic f, input logic [7:0] d, input logic [4:0] id,
                              input logic a, input logic s, input logic ie);
    exp_t e;
    e.ferr = f; e.data = d; e.id = id; e.act = a; e.strobe = s; e.iderr = ie;
    return e;
  endfunction

  // Every output pulse pops one expected record; pulses must last one cycle.
  always @(negedge clk) begin
    logic        pulse;
    exp_t        e;
    logic [17:0] obs;
    logic [17:0] req;
    pulse = rx_valid | frame_err | target_strobe | id_err;
    if (prev_pulse) begin
      total++;
      if (pulse) begin
        bad++;
        $display("FAIL pulse_width: pulse still high next cycle, required one-cycle pulse");
      end
    end
    prev_pulse = pulse;
    if (pulse) begin
      events++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: valid=%b ferr=%b strobe=%b iderr=%b, required no pulse",
                 rx_valid, frame_err, target_strobe, id_err);
      end else begin
        e   = exp_q.pop_front();
        obs = {rx_valid, frame_err, rx_data, target_id, target_active, target_strobe, id_err};
        req = {~e.ferr, e.ferr, e.data, e.id, e.act, e.strobe, e.iderr};
        if (obs !== req) begin
          bad++;
          $display("FAIL event: got v=%b fe=%b data=%h id=%0d act=%b stb=%b ie=%b, required v=%b fe=%b data=%h id=%0d act=%b stb=%b ie=%b",
                   obs[17], obs[16], obs[15:8], obs[7:3], obs[2], obs[1], obs[0],
                   req[17], req[16], req[15:8], req[7:3], req[2], req[1], req[0]);
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    if (bad_stop) begin
      drive(1'b0, 3 * CPB);
      drive(1'b1, 2 * CPB);
    end else begin
      drive(1'b1, CPB);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d expected events missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    rx  = 1'b1;

    tbl[0] = '{8'h0F, ex(1'b0, 8'h0F, 5'd3,  1'b1, 1'b1, 1'b0)};
    tbl[1] = '{8'h53, ex(1'b0, 8'h53, 5'd20, 1'b1, 1'b1, 1'b0)};
`ifdef TARGET_ID_CHECK_EN
    tbl[2] = '{8'h57, ex(1'b0, 8'h57, 5'd20, 1'b1, 1'b0, 1'b1)};
`else
    tbl[2] = '{8'h57, ex(1'b0, 8'h57, 5'd21, 1'b1, 1'b1, 1'b0)};
`endif
    tbl[3] = '{8'h00, ex(1'b0, 8'h00, 5'd0,  1'b0, 1'b1, 1'b0)};
    tbl[4] = '{8'h03, ex(1'b0, 8'h03, 5'd0,  1'b1, 1'b1, 1'b0)};
    tbl[5] = '{8'h03, ex(1'b0, 8'h03, 5'd0,  1'b1, 1'b1, 1'b0)};
    tbl[6] = '{8'h8F, ex(1'b0, 8'h8F, 5'd0,  1'b1, 1'b0, 1'b0)};
    tbl[7] = '{8'h24, ex(1'b0, 8'h24, 5'd0,  1'b1, 1'b0, 1'b0)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rx_data, rx_valid, target_id, target_active, target_strobe, frame_err, id_err} !== '0) begin
      bad++;
      $display("FAIL reset_state: data=%h v=%b id=%0d act=%b stb=%b fe=%b ie=%b, required all 0",
               rx_data, rx_valid, target_id, target_active, target_strobe, frame_err, id_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 5 * CPB);

    // Table frames go out back to back.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i].e);
      send_frame(tbl[i].b, 1'b0);
    end
    wait_drain();

    // Stop bit held low: one frame error, then the line recovers.
    exp_q.push_back(ex(1'b1, 8'h24, 5'd0, 1'b1, 1'b0, 1'b0));
    send_frame(8'h0F, 1'b1);
    exp_q.push_back(ex(1'b0, 8'h0B, 5'd2, 1'b1, 1'b1, 1'b0));
    send_frame(8'h0B, 1'b0);
    wait_drain();

    // Short low glitch must not start a frame.
    n0 = events;
    drive(1'b0, 3);
    drive(1'b1, 3 * CPB);
    total++;
    if (events != n0) begin
      bad++;
      $display("FAIL glitch: %0d pulses, required 0", events - n0);
    end
    exp_q.push_back(ex(1'b0, 8'h24, 5'd2, 1'b1, 1'b0, 1'b0));
    send_frame(8'h24, 1'b0);
    wait_drain();

    // Reset in the middle of data bit 4 of 0x0F.
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b0, 5);
    rst = 1'b1;
    drive(1'b0, 2);
    @(negedge clk);
    total++;
    if ({rx_data, rx_valid, target_id, target_active, target_strobe, frame_err, id_err} !== '0) begin
      bad++;
      $display("FAIL midframe_reset: data=%h v=%b id=%0d act=%b stb=%b fe=%b ie=%b, required all 0",
               rx_data, rx_valid, target_id, target_active, target_strobe, frame_err, id_err);
    end
    @(posedge clk);
    #1;
    rx  = 1'b1;
    rst = 1'b0;
    drive(1'b1, 3 * CPB);
    exp_q.push_back(ex(1'b0, 8'h0F, 5'd3, 1'b1, 1'b1, 1'b0));
    send_frame(8'h0F, 1'b0);
    wait_drain();
    drive(1'b1, 2 * CPB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
